hdmi_frame_decimator: RTL

Parametrised HDMI input conditioner for the multi-channel splicing path, one instance per video input. It keeps 1 of every N input frames, with N set at runtime. It optionally halves resolution in both dimensions for quadrant tiling: horizontal pair-averaging and odd-line drop. It converts pixels to RGB565, RGB888 or grey. Output keeps input timing (delayed, gated), so it must still pass through the frame buffer before VESA display.

---
 rtl/video_pkg.sv | 34 +++
 rtl/hdmi_pix_convert.sv | 48 ++++
 rtl/hdmi_frame_decimator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared pixel-format helpers for the multi-channel splicing path.
package video_pkg;

    localparam int unsigned OUT_RGB565 = 16;
    localparam int unsigned OUT_RGB888 = 24;

    localparam int unsigned LUMA_R = 77;
    localparam int unsigned LUMA_G = 150;
    localparam int unsigned LUMA_B = 29;

    // Coefficients sum to 256, so the 16-bit accumulator cannot overflow.
    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'(LUMA_R) * 16'(r) + 16'(LUMA_G) * 16'(g) + 16'(LUMA_B) * 16'(b);
        return 8'(acc >> 8);
    endfunction

    function automatic logic [15:0] pack565(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    function automatic logic [23:0] pack888(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        return {r, g, b};
    endfunction

    // wide = 1 selects RGB888 packing; otherwise RGB565 in the low 16 bits.
    function automatic logic [23:0] pack_gray(input logic [7:0] y, input logic wide);
        return wide ? {y, y, y} : {8'h00, y[7:3], y[7:2], y[7:3]};
    endfunction

endpackage

// File: rtl/hdmi_pix_convert.sv
// Stage-2 pixel formatter: colour/grey packing and output gating, one register stage.
module hdmi_pix_convert #(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       red,
    input  logic [7:0]       green,
    input  logic [7:0]       blue,
    input  logic             vs,
    input  logic             de,
    input  logic             gray,
    output logic             vs_out,
    output logic             de_out,
    output logic [OUT_W-1:0] pix_out
);
    import video_pkg::*;

    localparam bit WIDE = (OUT_W == OUT_RGB888);

    logic [OUT_W-1:0] px;

    // Select the packed format for the current pixel.
    always_comb begin
        px = '0;
        if (gray) begin
            px = OUT_W'(pack_gray(luma(red, green, blue), WIDE));
        end else if (WIDE) begin
            px = OUT_W'(pack888(red, green, blue));
        end else begin
            px = OUT_W'(pack565(red, green, blue));
        end
    end

    // Register outputs; pixel bus is forced to zero outside valid pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_out  <= 1'b0;
            de_out  <= 1'b0;
            pix_out <= '0;
        end else begin
            vs_out  <= vs;
            de_out  <= de;
            pix_out <= de ? px : '0;
        end
    end

endmodule

// File: rtl/hdmi_frame_decimator.sv
// HDMI input conditioner: frame decimation, optional 2:1 scaling, format conversion.
module hdmi_frame_decimator #(
    parameter int OUT_W   = 16,
    parameter int RATIO_W = 3,
    parameter int CNT_W   = 12
) (
    input  logic               hdmi_pix_clk_in,
    input  logic               rst,
    input  logic [7:0]         red_in,
    input  logic [7:0]         green_in,
    input  logic [7:0]         blue_in,
    input  logic               vs_in,
    input  logic               de_in,
    input  logic [RATIO_W-1:0] ratio_in,
    input  logic               scale_en,
    input  logic               gray_en,
    output logic               vs_out,
    output logic               de_out,
    output logic [OUT_W-1:0]   pix_out,
    output logic [7:0]         frame_tag
);
    logic               vs_d, de_d;
    logic               vs_rise, de_fall;
    logic [RATIO_W-1:0] idx, idx_next, ratio_new;
    logic [RATIO_W:0]   idx_inc;
    logic               primed, keep, keep_now;
    logic               scale_l, gray_l, scale_now, gray_now;
    logic               line_odd, emit;
    logic [CNT_W-1:0]   x, y;
    logic [7:0]         hold_r, hold_g, hold_b;
    logic [8:0]         sum_r, sum_g, sum_b;
    logic [7:0]         px_r, px_g, px_b;
    logic [7:0]         s1_r, s1_g, s1_b;
    logic               s1_vs, s1_de, s1_gray;

    // The ratio is only consumed at vs_rise, so the newly latched value is used
    // directly there; the first edge after reset always starts a kept frame.
    // Config and keep are forwarded on vs_rise so a coincident pixel sees the new frame state.
    always_comb begin
        vs_rise   = vs_in & ~vs_d;
        de_fall   = de_d & ~de_in;
        ratio_new = (ratio_in == '0) ? RATIO_W'(1) : ratio_in;
        idx_inc   = {1'b0, idx} + (RATIO_W+1)'(1);
        idx_next  = (!primed || idx_inc >= {1'b0, ratio_new}) ? '0 : idx_inc[RATIO_W-1:0];
        keep_now  = vs_rise ? (idx_next == '0) : keep;
        scale_now = vs_rise ? scale_en : scale_l;
        gray_now  = vs_rise ? gray_en : gray_l;
        line_odd  = ~vs_rise & y[0];
        emit      = de_in & (~scale_now | (~line_odd & x[0]));
        sum_r     = {1'b0, hold_r} + {1'b0, red_in};
        sum_g     = {1'b0, hold_g} + {1'b0, green_in};
        sum_b     = {1'b0, hold_b} + {1'b0, blue_in};
        px_r      = scale_now ? 8'(sum_r >> 1) : red_in;
        px_g      = scale_now ? 8'(sum_g >> 1) : green_in;
        px_b      = scale_now ? 8'(sum_b >> 1) : blue_in;
    end

    // Stage 1: sync detect, frame index, counters, pair hold and gated pixel register.
    always_ff @(posedge hdmi_pix_clk_in) begin
        if (rst) begin
            vs_d      <= 1'b0;
            de_d      <= 1'b0;
            idx       <= '0;
            primed    <= 1'b0;
            keep      <= 1'b0;
            scale_l   <= 1'b0;
            gray_l    <= 1'b0;
            frame_tag <= '0;
            x         <= '0;
            y         <= '0;
            hold_r    <= '0;
            hold_g    <= '0;
            hold_b    <= '0;
            s1_r      <= '0;
            s1_g      <= '0;
            s1_b      <= '0;
            s1_vs     <= 1'b0;
            s1_de     <= 1'b0;
            s1_gray   <= 1'b0;
        end else begin
            vs_d <= vs_in;
            de_d <= de_in;
            if (vs_rise) begin
                idx     <= idx_next;
                keep    <= (idx_next == '0);
                primed  <= 1'b1;
                scale_l <= scale_en;
                gray_l  <= gray_en;
                if (idx_next == '0) begin
                    frame_tag <= frame_tag + 8'd1;
                end
            end
            if (!de_in) begin
                x <= '0;
            end else if (x != '1) begin
                x <= x + CNT_W'(1);
            end
            if (vs_rise) begin
                y <= '0;
            end else if (de_fall && y != '1) begin
                y <= y + CNT_W'(1);
            end
            if (de_in && !x[0]) begin
                hold_r <= red_in;
                hold_g <= green_in;
                hold_b <= blue_in;
            end
            s1_r    <= px_r;
            s1_g    <= px_g;
            s1_b    <= px_b;
            s1_vs   <= vs_in & keep_now;
            s1_de   <= emit & keep_now;
            s1_gray <= gray_now;
        end
    end

    hdmi_pix_convert #(.OUT_W(OUT_W)) u_convert (
        .clk     (hdmi_pix_clk_in),
        .rst     (rst),
        .red     (s1_r),
        .green   (s1_g),
        .blue    (s1_b),
        .vs      (s1_vs),
        .de      (s1_de),
        .gray    (s1_gray),
        .vs_out  (vs_out),
        .de_out  (de_out),
        .pix_out (pix_out)
    );

endmodule
